// File: rtl/aes_key_expand.sv
// AES-128 iterative key schedule. Emits round keys 0..10 one per accepted
// transfer on a valid/ready port, then pulses done for one cycle.
// SubWord uses four combinational sbox instances fed from the key register.

// AES forward S-box computed from its algebraic definition: the GF(2^8)
// multiplicative inverse followed by the affine transform. The inverse is
// formed as x^254 with a short square-and-multiply chain, which maps 0 to 0.
module sbox (
  input  logic [7:0] a,
  output logic [7:0] s
);

  // Shift-and-add multiply in GF(2^8), reduction polynomial x^8+x^4+x^3+x+1.
  function automatic logic [7:0] gmul(input logic [7:0] x, input logic [7:0] y);
    logic [7:0] p;
    logic [7:0] xx;
    p  = 8'h00;
    xx = x;
    for (int i = 0; i < 8; i++) begin
      if (y[i]) p = p ^ xx;
      xx = {xx[6:0], 1'b0} ^ (xx[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  logic [7:0] x2, x3, x6, x7, x14, x15, x30, x31;
  logic [7:0] x62, x63, x126, x127, inv;

  // Inverse via exponent chain, then the affine map b ^ rotl1..rotl4 ^ 0x63.
  always_comb begin
    x2   = gmul(a, a);
    x3   = gmul(x2, a);
    x6   = gmul(x3, x3);
    x7   = gmul(x6, a);
    x14  = gmul(x7, x7);
    x15  = gmul(x14, a);
    x30  = gmul(x15, x15);
    x31  = gmul(x30, a);
    x62  = gmul(x31, x31);
    x63  = gmul(x62, a);
    x126 = gmul(x63, x63);
    x127 = gmul(x126, a);
    inv  = gmul(x127, x127);
    s    = inv
         ^ {inv[6:0], inv[7]}
         ^ {inv[5:0], inv[7:6]}
         ^ {inv[4:0], inv[7:5]}
         ^ {inv[3:0], inv[7:4]}
         ^ 8'h63;
  end

endmodule

module aes_key_expand (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [127:0] key_in,
  input  logic         rk_ready,
  output logic         rk_valid,
  output logic [127:0] rk_out,
  output logic [3:0]   rk_round,
  output logic         busy,
  output logic         done
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EMIT = 2'd1,
    FIN  = 2'd2
  } state_t;

  state_t       state_reg, state_next;
  logic [127:0] key_reg, key_next;
  logic [3:0]   round_reg, round_next;
  logic [7:0]   rcon_reg, rcon_next;

  logic [31:0]  w0, w1, w2, w3;
  logic [31:0]  rot_w, sub_w, t;
  logic [31:0]  n0, n1, n2, n3;
  logic [127:0] next_key;
  logic         xfer;

  assign w0 = key_reg[127:96];
  assign w1 = key_reg[95:64];
  assign w2 = key_reg[63:32];
  assign w3 = key_reg[31:0];

  // RotWord: byte-rotate left by one before substitution.
  assign rot_w = {w3[23:0], w3[31:24]};

  // SubWord: one sbox per byte lane, lanes kept in place.
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_sbox
      sbox u_sbox (
        .a (rot_w[gi*8 +: 8]),
        .s (sub_w[gi*8 +: 8])
      );
    end
  endgenerate

  assign t  = sub_w ^ {rcon_reg, 24'h000000};
  assign n0 = w0 ^ t;
  assign n1 = w1 ^ n0;
  assign n2 = w2 ^ n1;
  assign n3 = w3 ^ n2;
  assign next_key = {n0, n1, n2, n3};

  assign xfer = (state_reg == EMIT) && rk_ready;

  // Next-state and datapath update; everything holds unless a transfer or
  // an accepted start occurs. FIN accepts start exactly like IDLE.
  always_comb begin
    state_next = state_reg;
    key_next   = key_reg;
    round_next = round_reg;
    rcon_next  = rcon_reg;
    case (state_reg)
      IDLE, FIN: begin
        if (start) begin
          state_next = EMIT;
          key_next   = key_in;
          round_next = 4'd0;
          rcon_next  = 8'h01;
        end else begin
          state_next = IDLE;
        end
      end
      EMIT: begin
        if (xfer) begin
          if (round_reg == 4'd10) begin
            // Last key handed off; register left untouched.
            state_next = FIN;
          end else begin
            key_next   = next_key;
            round_next = round_reg + 4'd1;
            rcon_next  = {rcon_reg[6:0], 1'b0} ^ (rcon_reg[7] ? 8'h1b : 8'h00);
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // State and key registers; reset clears everything immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      key_reg   <= 128'h0;
      round_reg <= 4'd0;
      rcon_reg  <= 8'h01;
    end else begin
      state_reg <= state_next;
      key_reg   <= key_next;
      round_reg <= round_next;
      rcon_reg  <= rcon_next;
    end
  end

  // All outputs decode straight from registers, never from rk_ready.
  assign rk_valid = (state_reg == EMIT);
  assign busy     = (state_reg == EMIT);
  assign done     = (state_reg == FIN);
  assign rk_out   = key_reg;
  assign rk_round = round_reg;

endmodule
